// File: rtl/gamma_channel_sequencer.sv
// Time-shares one 8->8 gamma LUT over the G, R and B bytes of a GRB pixel (1 pixel / 5 clk).
// Optional feature: define BRIGHTNESS_SCALE_EN to pre-scale each byte by the brightness latched at accept.
module gamma_channel_sequencer #(
  parameter int NUM_LEDS = 60,
  parameter int IDX_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_sync,
  input  logic [7:0]  brightness,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_pixel,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CH_G = 3'd1,
    S_CH_R = 3'd2,
    S_CH_B = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t             state_q, state_d;
  logic [23:0]        pix_q, pix_d;
  logic [23:0]        out_pixel_q, out_pixel_d;
  logic [IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic [7:0]         bright_q, bright_d;
  logic               in_ready_s;
  logic [7:0]         lut_sel_s;
  logic [7:0]         lut_in_s;
  logic [7:0]         lut_out_s;

`ifdef BRIGHTNESS_SCALE_EN
  // 255 maps to identity, 0 maps every channel to 0.
  function automatic logic [7:0] scale_byte(input logic [7:0] b, input logic [7:0] br);
    logic [15:0] prod;
    prod = {8'd0, b} * ({8'd0, br} + 16'd1);
    return prod[15:8];
  endfunction

  assign lut_in_s = scale_byte(lut_sel_s, bright_q);
`else
  logic unused_brightness_s;
  assign unused_brightness_s = ^{brightness, bright_q};
  assign lut_in_s = lut_sel_s;
`endif

  gamma_correction_LUT u_lut (
    .lut_in  (lut_in_s),
    .lut_out (lut_out_s)
  );

  // Next-state, channel select and output-register updates; frame_sync overrides everything.
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    bright_d    = bright_q;
    out_pixel_d = out_pixel_q;
    pix_idx_d   = pix_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    lut_sel_s   = 8'd0;
    in_ready_s  = (state_q == S_IDLE) && !frame_sync;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_s) begin
          pix_d    = in_pixel;
          bright_d = brightness;
          state_d  = S_CH_G;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_CH_G: begin
        lut_sel_s          = pix_q[23:16];
        out_pixel_d[23:16] = lut_out_s;
        state_d            = S_CH_R;
      end
      S_CH_R: begin
        lut_sel_s          = pix_q[15:8];
        out_pixel_d[15:8]  = lut_out_s;
        state_d            = S_CH_B;
      end
      S_CH_B: begin
        lut_sel_s          = pix_q[7:0];
        out_pixel_d[7:0]   = lut_out_s;
        out_valid_d        = 1'b1;
        out_last_d         = (pix_idx_q == LAST_IDX);
        state_d            = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          pix_idx_d   = (pix_idx_q == LAST_IDX) ? {IDX_W{1'b0}} : (pix_idx_q + IDX_ONE);
          state_d     = S_IDLE;
        end else begin
          state_d     = S_OUT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    // A handshake coinciding with frame_sync still delivers, but the index restarts at 0.
    if (frame_sync) begin
      state_d     = S_IDLE;
      pix_idx_d   = {IDX_W{1'b0}};
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      pix_idx_d   = pix_idx_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pix_q       <= 24'd0;
      bright_q    <= 8'd0;
      out_pixel_q <= 24'd0;
      pix_idx_q   <= {IDX_W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      bright_q    <= bright_d;
      out_pixel_q <= out_pixel_d;
      pix_idx_q   <= pix_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// Combinational 8->8 gamma 2.0 curve: ceil(x*x/256), so 0->0 and 255->255.
module gamma_correction_LUT (
  input  logic [7:0] lut_in,
  output logic [7:0] lut_out
);

  logic [15:0] sq_s;

  // Square plus 255 rounds the divide-by-256 upward; the max sum 65280 fits 16 bits.
  always_comb begin
    sq_s    = ({8'd0, lut_in} * {8'd0, lut_in}) + 16'd255;
    lut_out = sq_s[15:8];
  end

endmodule

// File: tb/tb_gamma_channel_sequencer.sv
// Directed bench for gamma_channel_sequencer with a pixel scoreboard and immediate-assertion checks.
module tb_gamma_channel_sequencer;

  localparam int NUM_LEDS = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_sync = 1'b0;
  logic [7:0]  brightness = 8'd255;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_pixel = 24'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_pixel;
  logic        out_last;
  logic        busy;

  int total = 0;
  int bad = 0;
  logic [23:0] exp_q[$];
  int exp_idx = 0;

  gamma_channel_sequencer #(.NUM_LEDS(NUM_LEDS), .IDX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_sync (frame_sync),
    .brightness (brightness),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lut_m(input logic [7:0] x);
    int sq;
    int q;
    sq = int'(x) * int'(x);
    q = sq / 256;
    if (q * 256 != sq) q = q + 1;
    return q[7:0];
  endfunction

  function automatic logic [7:0] scale_m(input logic [7:0] b, input logic [7:0] br);
    int p;
`ifdef BRIGHTNESS_SCALE_EN
    p = (int'(b) * (int'(br) + 1)) / 256;
`else
    p = int'(b) + 0 * int'(br);
`endif
    return p[7:0];
  endfunction

  function automatic logic [23:0] exp_pix(input logic [23:0] p, input logic [7:0] br);
    return {lut_m(scale_m(p[23:16], br)), lut_m(scale_m(p[15:8], br)), lut_m(scale_m(p[7:0], br))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes just before the rising edge, update the scoreboard, return at the falling edge.
  task automatic tick(output bit acc, output bit hs);
    logic [23:0] e;
    #1;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_out_pixel", out_pixel, e);
        chk("sb_out_last", out_last, (exp_idx == NUM_LEDS - 1));
      end
    end
    if (frame_sync) begin
      exp_q.delete();
      exp_idx = 0;
    end else if (hs) begin
      exp_idx = (exp_idx == NUM_LEDS - 1) ? 0 : exp_idx + 1;
    end
    if (acc) exp_q.push_back(exp_pix(in_pixel, brightness));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stream(input int n, output int nlast, output int last_pos);
    int acc_n;
    int got;
    int cyc;
    int last_hs;
    bit a;
    bit h;
    logic lst;
    acc_n = 0; got = 0; cyc = 0; last_hs = -1;
    nlast = 0; last_pos = 0;
    out_ready = 1'b1;
    while (got < n && cyc < n * 5 + 20) begin
      in_valid = (acc_n < n);
      in_pixel = 24'($urandom);
      lst = out_last;
      tick(a, h);
      if (a) acc_n++;
      if (h) begin
        got++;
        if (last_hs >= 0) chk("stream_interval", cyc - last_hs, 5);
        last_hs = cyc;
        if (lst) begin
          nlast++;
          if (last_pos == 0) last_pos = got;
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", got, n);
  endtask

  initial begin
    bit a;
    bit h;
    int nl;
    int lp;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single pixel, latency 4, no backpressure
    in_pixel = 24'hFF00FF; in_valid = 1'b1; out_ready = 1'b1;
    tick(a, h);
    chk("t2_accept", a, 1);
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("t2_in_ready_low", in_ready, 0);
      chk("t2_out_valid", out_valid, (c == 4));
      if (c == 4) begin
        chk("t2_out_pixel", out_pixel, 24'hFF00FF);
        chk("t2_out_last", out_last, 0);
      end
      tick(a, h);
    end
    chk("t2_ready_again", in_ready, 1);

    // Backpressure: output held stable
    in_pixel = 24'h804020; in_valid = 1'b1; out_ready = 1'b0;
    tick(a, h);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick(a, h);
    for (int c = 0; c < 10; c++) begin
      chk("t3_out_valid", out_valid, 1);
      chk("t3_out_pixel", out_pixel, exp_pix(24'h804020, 8'd255));
      chk("t3_in_ready", in_ready, 0);
      tick(a, h);
    end
    out_ready = 1'b1;
    tick(a, h);
    chk("t3_out_pixel_kept", out_pixel, exp_pix(24'h804020, 8'd255));

    // Async reset while stalled in OUT
    in_pixel = 24'h123456; in_valid = 1'b1; out_ready = 1'b0;
    tick(a, h);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick(a, h);
    chk("t1_pre_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", out_valid, 0);
    chk("t1_out_pixel", out_pixel, 0);
    chk("t1_out_last", out_last, 0);
    chk("t1_busy", busy, 0);
    exp_q.delete();
    exp_idx = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("t1_no_output", out_valid, 0);
      chk("t1_in_ready", in_ready, 1);
      tick(a, h);
    end

    // 61-pixel stream: last flag only on the 60th
    stream(61, nl, lp);
    chk("t4_last_count", nl, 1);
    chk("t4_last_pos", lp, 60);

    // frame_sync blocks a same-cycle accept
    frame_sync = 1'b1; in_valid = 1'b1; in_pixel = 24'hAAAAAA;
    #1;
    chk("t5_fs_in_ready", in_ready, 0);
    tick(a, h);
    chk("t5_fs_no_accept", a, 0);
    frame_sync = 1'b0; in_valid = 1'b0;

    // frame_sync during CH_R of pixel 7 drops it
    stream(7, nl, lp);
    in_pixel = 24'h5A5A5A; in_valid = 1'b1;
    tick(a, h);
    in_valid = 1'b0;
    tick(a, h);
    frame_sync = 1'b1;
    tick(a, h);
    frame_sync = 1'b0;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_out_valid", out_valid, 0);
    for (int c = 0; c < 5; c++) begin
      chk("t5_dropped", out_valid, 0);
      tick(a, h);
    end
    stream(60, nl, lp);
    chk("t5_last_pos", lp, 60);

    // frame_sync together with an output handshake
    in_pixel = 24'h0F1E2D; in_valid = 1'b1; out_ready = 1'b0;
    tick(a, h);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick(a, h);
    out_ready = 1'b1; frame_sync = 1'b1;
    tick(a, h);
    chk("fs_hs_delivered", h, 1);
    frame_sync = 1'b0;
    stream(60, nl, lp);
    chk("fs_hs_last_pos", lp, 60);

`ifdef BRIGHTNESS_SCALE_EN
    // Brightness latched at accept
    brightness = 8'd0; in_pixel = 24'hFFFFFF; in_valid = 1'b1; out_ready = 1'b0;
    tick(a, h);
    in_valid = 1'b0; brightness = 8'd255;
    for (int c = 0; c < 3; c++) tick(a, h);
    chk("t6_dark", out_pixel, 24'h000000);
    out_ready = 1'b1;
    tick(a, h);
    brightness = 8'd255; in_valid = 1'b1; out_ready = 1'b0;
    tick(a, h);
    in_valid = 1'b0; brightness = 8'd0;
    for (int c = 0; c < 3; c++) tick(a, h);
    chk("t6_full", out_pixel, 24'hFFFFFF);
    out_ready = 1'b1;
    tick(a, h);
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
